// File: rtl/inst_rom_loader.sv
// Instruction memory for the CPU fetch port, with a byte-serial loader that
// assembles big-endian words and holds the CPU in reset while an image streams in.
module inst_rom_loader #(
    parameter int unsigned ADDR_WIDTH    = 10,
    parameter bit          HOLD_AT_RESET = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce_i,
    input  logic [31:0]           addr_i,
    output logic [31:0]           inst_o,
    input  logic                  ld_start_i,
    input  logic [7:0]            ld_byte_i,
    input  logic                  ld_valid_i,
    input  logic                  ld_last_i,
    output logic                  ld_ready_o,
    output logic                  ld_busy_o,
    output logic [ADDR_WIDTH:0]   ld_words_o,
    output logic                  ld_err_o,
    output logic                  cpu_hold_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state;
    logic [1:0]              byte_cnt;
    logic [ADDR_WIDTH-1:0]   wr_ptr;
    logic [31:0]             asm_word;
    logic [31:0]             asm_next;
    logic [31:0]             mem [DEPTH];
    logic                    accept;
    logic                    word_done;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   fetch_idx;
    logic                    unused_addr;

    // Byte 0 of each word lands in the MSB; unfilled bytes stay zero.
    always_comb begin
        asm_next = asm_word;
        case (byte_cnt)
            2'd0:    asm_next[31:24] = ld_byte_i;
            2'd1:    asm_next[23:16] = ld_byte_i;
            2'd2:    asm_next[15:8]  = ld_byte_i;
            default: asm_next[7:0]   = ld_byte_i;
        endcase
    end

    assign accept    = (state == LOAD) && ld_valid_i;
    assign word_done = accept && ((byte_cnt == 2'd3) || ld_last_i);
    assign mem_we    = rst && word_done;

    assign ld_ready_o = (state == LOAD);
    assign ld_busy_o  = (state != IDLE);

    // Fetch ignores the byte offset and any address bits above the array.
    assign fetch_idx   = addr_i[ADDR_WIDTH+1:2];
    assign unused_addr = ^{addr_i[31:ADDR_WIDTH+2], addr_i[1:0]};
    assign inst_o      = (rst && ce_i && (state == IDLE)) ? mem[fetch_idx] : 32'h0;

    // Image storage survives reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr] <= asm_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            byte_cnt   <= 2'd0;
            wr_ptr     <= '0;
            asm_word   <= 32'h0;
            ld_words_o <= '0;
            ld_err_o   <= 1'b0;
            cpu_hold_o <= HOLD_AT_RESET;
        end else begin
            case (state)
                IDLE: begin
                    if (ld_start_i) begin
                        state      <= LOAD;
                        byte_cnt   <= 2'd0;
                        wr_ptr     <= '0;
                        asm_word   <= 32'h0;
                        ld_words_o <= '0;
                        ld_err_o   <= 1'b0;
                        cpu_hold_o <= 1'b1;
                    end
                end
                LOAD: begin
                    if (word_done) begin
                        asm_word   <= 32'h0;
                        byte_cnt   <= 2'd0;
                        wr_ptr     <= wr_ptr + ADDR_WIDTH'(1);
                        ld_words_o <= ld_words_o + (ADDR_WIDTH+1)'(1);
                        if (ld_last_i) begin
                            state <= DONE;
                            if (byte_cnt != 2'd3) begin
                                ld_err_o <= 1'b1;
                            end
                        end else if (&wr_ptr) begin
                            // Array full with more image pending: stop rather than wrap.
                            ld_err_o <= 1'b1;
                            state    <= DONE;
                        end
                    end else if (accept) begin
                        asm_word <= asm_next;
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    cpu_hold_o <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/inst_rom_loader.md
Name: inst_rom_loader

Overview:
- Instruction-memory responder for the CPU fetch interface: answers the core's chip-enable/address with an instruction word in the same cycle.
- Also contains a byte-serial program loader: a stream of bytes is assembled big-endian into 32-bit words and written sequentially from word 0.
- While a load is in progress, the CPU is held in reset.
- Sits beside the mips core in the SoC top: fetch ports connect to the core's ROM address/enable/data; loader ports connect to a UART/debug byte source.

Parameters:
- ADDR_WIDTH, 10, word-address width; depth DEPTH = 2**ADDR_WIDTH words.
- HOLD_AT_RESET, 0, value of cpu_hold_o out of reset (1 = hold the CPU until the first load completes).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous reset, active-low.
- ce_i  in  1  fetch enable from the CPU.
- addr_i  in  32  fetch byte address from the CPU.
- inst_o  out  32  fetched instruction to the CPU.
- ld_start_i  in  1  single-cycle pulse that begins a load.
- ld_byte_i  in  8  load data byte.
- ld_valid_i  in  1  ld_byte_i valid.
- ld_last_i  in  1  qualifies the accepted byte as the final byte of the image.
- ld_ready_o  out  1  loader can accept a byte this cycle.
- ld_busy_o  out  1  loader is in LOAD or DONE.
- ld_words_o  out  ADDR_WIDTH+1  words written by the latest load.
- ld_err_o  out  1  latest load was truncated or overflowed (sticky).
- cpu_hold_o  out  1  drive to the CPU reset; 1 = hold the CPU in reset.

Behaviour:
- Reset (rst low at an edge):
  - State = IDLE; byte count, word pointer, assembly register, ld_words_o and ld_err_o cleared.
  - cpu_hold_o = HOLD_AT_RESET.
  - Memory contents are not cleared.
  - Reset mid-load discards any partial word; words already written remain.
- Fetch (combinational):
  - Word index = addr_i[ADDR_WIDTH+1:2]; addr_i[1:0] and addresses above the array are ignored (addresses alias).
  - inst_o = mem[index] when ce_i=1 and state=IDLE; otherwise 0 (NOP).
  - inst_o is 0 while rst is low.
- FSM states: IDLE, LOAD, DONE.
  - IDLE -> LOAD on ld_start_i. Same edge: pointer=0, byte count=0, ld_words_o=0, ld_err_o=0, cpu_hold_o=1.
  - LOAD:
    - ld_ready_o=1; a byte is accepted on ld_valid_i & ld_ready_o.
    - Byte k of the word (k=0..3) goes to bits [31-8k:24-8k]; byte 0 is the MSB.
    - When the 4th byte is accepted, the word is written to mem[pointer] at that edge; pointer and ld_words_o increment; byte count returns to 0.
    - ld_last_i on a 4th byte: write the word, go to DONE.
    - ld_last_i on byte 0-2: zero-pad the remaining bytes, write at that edge, increment ld_words_o, set ld_err_o=1, go to DONE.
    - Writing word DEPTH-1 without ld_last_i: set ld_err_o=1 (overflow), go to DONE. No wrap to word 0.
    - ld_start_i is ignored in LOAD.
  - DONE: lasts exactly one cycle; ld_ready_o=0; cpu_hold_o=1. Next edge -> IDLE with cpu_hold_o=0.
  - IDLE: ld_ready_o=0; bytes and ld_last_i presented in IDLE are ignored, including in the same cycle as ld_start_i.
- Status outputs:
  - ld_busy_o = (state != IDLE), combinational.
  - ld_words_o and ld_err_o hold their values until the next ld_start_i or reset.
  - cpu_hold_o is registered.
- The first CPU fetch after a load sees the new image: the CPU leaves reset the cycle after DONE, and fetch data is combinational.

Test Plan:
- Reset with rst=0 for 2 cycles, HOLD_AT_RESET=0 -> cpu_hold_o=0, ld_busy_o=0, ld_ready_o=0, ld_words_o=0, ld_err_o=0, inst_o=0 during reset.
- Start pulse, then bytes 24,01,00,05 / 00,00,00,00 with ld_last_i on the 8th byte -> mem[0]=0x24010005, mem[1]=0x00000000, ld_words_o=2, ld_err_o=0, cpu_hold_o high from the start edge through DONE; then ce_i=1, addr_i=0x0 -> inst_o=0x24010005; addr_i=0x6 -> 0x00000000.
- Bytes AA,BB then ld_last_i with byte CC -> mem[0]=0xAABBCC00, ld_words_o=1, ld_err_o=1; a following ld_start_i clears ld_err_o.
- ADDR_WIDTH=2: stream 20 bytes without ld_last_i -> 4 words written, DONE after the 16th byte, ld_err_o=1, bytes 17-20 not accepted (ld_ready_o=0), mem[0] unchanged by the overflow.
- ld_valid_i held high with gaps in LOAD, and ld_start_i pulsed mid-load -> only valid bytes are counted, the second start is ignored, ld_words_o stays correct; ce_i=1 during LOAD -> inst_o=0.
- rst low after 2 of 4 bytes of word 3 -> IDLE, cpu_hold_o=HOLD_AT_RESET, words 0-2 still readable, word 3 unchanged.
